// File: rtl/fir_sample_feeder.sv
// Elastic input buffer for the transposed FIR filter: a small FIFO accepts
// samples from a valid/ready source. One sample at a time is presented to the filter.
module fir_sample_feeder #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [DATA_WIDTH-1:0]         iv_s_data,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    output logic [DATA_WIDTH-1:0]         ov_dout,
    output logic                          o_dout_valid,
    input  logic                          i_consumed,
    output logic [$clog2(FIFO_DEPTH):0]   ov_level,
    output logic                          o_overrun
);

    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LEVEL_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic [LEVEL_W-1:0]      count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    dout_valid_next;
    logic [DATA_WIDTH-1:0]   dout_next;

    // Ready is decoded from the registered count, so a full FIFO refuses a
    // push even when a pop happens on the same edge.
    assign full      = (count == LEVEL_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign o_s_ready = i_en && !full;
    assign push      = i_s_valid && o_s_ready;
    assign ov_level  = count;

    // Output FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, pop decision and next output values
    always_comb begin
        state_next      = state;
        pop             = 1'b0;
        dout_next       = ov_dout;
        dout_valid_next = o_dout_valid;
        if (i_en) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop             = 1'b1;
                        dout_next       = mem[rd_ptr];
                        dout_valid_next = 1'b1;
                        state_next      = PRESENT;
                    end
                end
                PRESENT: begin
                    if (i_consumed) begin
                        dout_valid_next = 1'b0;
                        state_next      = GAP;
                    end
                end
                GAP: begin
                    // One dead cycle so the filter never sees the same sample twice
                    dout_valid_next = 1'b0;
                    state_next      = IDLE;
                end
                default: begin
                    dout_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            endcase
        end
    end

    // Pointers, occupancy, presented sample and sticky overrun flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            ov_dout      <= dout_next;
            o_dout_valid <= dout_valid_next;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LEVEL_W'(1);
                2'b01:   count <= count - LEVEL_W'(1);
                default: count <= count;
            endcase
            if (i_en && i_s_valid && full) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // Sample storage; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= iv_s_data;
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: a transaction-level queue model
// predicts every output each cycle; scenario tasks add directed checks.
module tb_fir_sample_feeder;

    localparam int unsigned DW = 24;
    localparam int unsigned D  = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned VW = 1 + DW + LW + 1 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          consumed;
    logic [LW-1:0] level;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: buffered samples, presented sample, one-cycle gap after release
    logic [DW-1:0] m_q[$];
    bit            m_present = 1'b0;
    bit            m_gap     = 1'b0;
    bit            m_ovr     = 1'b0;
    bit            m_acc     = 1'b0;
    logic [DW-1:0] m_dout    = '0;

    fir_sample_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .iv_s_data   (s_data),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .ov_dout     (dout),
        .o_dout_valid(dout_valid),
        .i_consumed  (consumed),
        .ov_level    (level),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {dout_valid, dout, level, s_ready, overrun};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        logic          rdy;
        logic [LW-1:0] lvl;
        rdy = en && (m_q.size() != D);
        lvl = LW'(m_q.size());
        return {m_present, m_dout, lvl, rdy, m_ovr};
    endfunction

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        bit full;
        bit can_pop;
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_present = 1'b0;
            m_gap     = 1'b0;
            m_ovr     = 1'b0;
            m_dout    = '0;
        end else if (en) begin
            full    = (m_q.size() == D);
            can_pop = !m_present && !m_gap && (m_q.size() != 0);
            if (s_valid && full) m_ovr = 1'b1;
            if (m_present) begin
                if (consumed) begin
                    m_present = 1'b0;
                    m_gap     = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (can_pop) begin
                m_dout    = m_q.pop_front();
                m_present = 1'b1;
            end
            if (s_valid && !full) begin
                m_q.push_back(s_data);
                m_acc = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; s_valid = 1'b0; consumed = 1'b0; s_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
        end
        n_cmp++;
        if ({dout_valid, dout, level, overrun, s_ready} !== {1'b0, 24'h0, 4'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_values: got v=%b d=%h l=%0d o=%b r=%b want 0 0 0 0 1",
                              dout_valid, dout, level, overrun, s_ready);
        end
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 24'h123456;
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if ({dout_valid, level} !== {1'b0, 4'd1}) begin
            n_err++; $display("FAIL single_accept: got v=%b l=%0d want v=0 l=1", dout_valid, level);
        end
        tick();
        n_cmp++;
        if ({dout_valid, dout, level} !== {1'b1, 24'h123456, 4'd0}) begin
            n_err++; $display("FAIL single_present: got v=%b d=%h l=%0d want 1 123456 0",
                              dout_valid, dout, level);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL single_hold: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        consumed = 1'b1;
        tick();
        consumed = 1'b0;
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 24'h123456) begin
            n_err++; $display("FAIL single_release: got v=%b d=%h want 0 123456", dout_valid, dout);
        end
        tick();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL single_gap: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] got[$];
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            s_valid = 1'b1; s_data = DW'(k);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL burst_fill: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if ({level, s_ready, dout_valid, dout} !== {4'd8, 1'b0, 1'b1, 24'd1}) begin
            n_err++; $display("FAIL burst_full: got l=%0d r=%b v=%b d=%h want 8 0 1 1",
                              level, s_ready, dout_valid, dout);
        end
        s_data = 24'd10;
        tick();
        tick();
        n_cmp++;
        if ({overrun, level} !== {1'b1, 4'd8}) begin
            n_err++; $display("FAIL burst_overrun: got o=%b l=%0d want 1 8", overrun, level);
        end
        for (int c = 0; c < 300 && got.size() < 10; c++) begin
            consumed = dout_valid;
            if (dout_valid) got.push_back(dout);
            tick();
            if (m_acc) s_valid = 1'b0;
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL burst_drain: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        consumed = 1'b0;
        s_valid  = 1'b0;
        n_cmp++;
        if (got.size() != 10) begin
            n_err++; $display("FAIL burst_count: got %0d outputs want 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== DW'(i + 1)) begin
                n_err++; $display("FAIL burst_order[%0d]: got %h want %h", i, got[i], DW'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] got[$];
        int            next_val = 1;
        int            max_lvl  = 0;
        bit            held     = 1'b0;
        do_reset();
        for (int c = 0; c < 2000 && got.size() < 40; c++) begin
            s_valid  = (next_val <= 40) && ($urandom_range(0, 3) != 0);
            s_data   = DW'(next_val);
            consumed = dout_valid && held;
            if (consumed) got.push_back(dout);
            held = dout_valid;
            tick();
            if (m_acc) next_val++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL wrap_cycle: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        s_valid = 1'b0; consumed = 1'b0;
        n_cmp++;
        if (got.size() != 40 || max_lvl > 8) begin
            n_err++; $display("FAIL wrap_summary: got %0d outputs max_level %0d want 40 <=8",
                              got.size(), max_lvl);
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== DW'(i + 1)) begin
                n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], DW'(i + 1));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] got[$];
        logic [DW-1:0] exp_seq[$];
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1; s_data = DW'(24'hA0 + k);
            tick();
        end
        s_valid = 1'b0;
        n_cmp++;
        if ({level, dout_valid, dout} !== {4'd3, 1'b1, 24'hA1}) begin
            n_err++; $display("FAIL simul_setup: got l=%0d v=%b d=%h want 3 1 a1", level, dout_valid, dout);
        end
        consumed = 1'b1; tick(); consumed = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 24'hA5;
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if ({level, dout_valid, dout} !== {4'd3, 1'b1, 24'hA2}) begin
            n_err++; $display("FAIL simul_pushpop: got l=%0d v=%b d=%h want 3 1 a2", level, dout_valid, dout);
        end
        for (int k = 1; k <= 5; k++) begin
            s_valid = 1'b1; s_data = DW'(24'hB0 + k);
            tick();
        end
        s_valid = 1'b0;
        consumed = 1'b1; tick(); consumed = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 24'hBF;
        tick();
        s_valid = 1'b0;
        n_cmp++;
        if ({level, dout_valid, dout, overrun} !== {4'd7, 1'b1, 24'hA3, 1'b1}) begin
            n_err++; $display("FAIL simul_full: got l=%0d v=%b d=%h o=%b want 7 1 a3 1",
                              level, dout_valid, dout, overrun);
        end
        exp_seq = '{24'hA3, 24'hA4, 24'hA5, 24'hB1, 24'hB2, 24'hB3, 24'hB4, 24'hB5};
        for (int c = 0; c < 200 && got.size() < 8; c++) begin
            consumed = dout_valid;
            if (dout_valid) got.push_back(dout);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL simul_drain: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        consumed = 1'b0;
        n_cmp++;
        if (got !== exp_seq) begin
            n_err++; $display("FAIL simul_order: got %p want %p", got, exp_seq);
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_enable_freeze();
        logic [VW-1:0] snap;
        logic [VW-1:0] mask;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1'b1; s_data = DW'($urandom);
            tick();
        end
        s_valid = 1'b0;
        snap = mdl_vec();
        mask = ~(VW'(1) << 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid  = 1'($urandom);
            consumed = 1'($urandom);
            s_data   = DW'($urandom);
            tick();
            n_cmp++;
            if (((dut_vec() & mask) !== (snap & mask)) || s_ready !== 1'b0) begin
                n_err++; $display("FAIL freeze_hold: got %h want %h (ready low)", dut_vec(), snap);
            end
        end
        en = 1'b1; s_valid = 1'b0; consumed = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec() !== mdl_vec() || level !== 4'd2 || dout_valid !== 1'b1) begin
            n_err++; $display("FAIL freeze_resume: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_reset_mid();
        // Leave overrun set so the reset is seen to clear it
        for (int k = 1; k <= 10; k++) begin
            s_valid = 1'b1; s_data = DW'(24'hC0 + k);
            tick();
        end
        for (int c = 0; c < 20 && level > 4'd5; c++) begin
            s_valid  = 1'b0;
            consumed = dout_valid;
            tick();
        end
        consumed = 1'b0;
        while (!dout_valid) tick();
        n_cmp++;
        if ({level, dout_valid, overrun} !== {4'd5, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL rstmid_setup: got l=%0d v=%b o=%b want 5 1 1", level, dout_valid, overrun);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++;
        if ({dout_valid, level, overrun} !== {1'b0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL rstmid_clear: got v=%b l=%0d o=%b want 0 0 0", dout_valid, level, overrun);
        end
        s_valid = 1'b1; s_data = 24'h5A5A5A;
        tick();
        s_valid = 1'b0;
        tick();
        n_cmp++;
        if ({dout_valid, dout} !== {1'b1, 24'h5A5A5A}) begin
            n_err++; $display("FAIL rstmid_first: got v=%b d=%h want 1 5a5a5a", dout_valid, dout);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            s_valid  = 1'($urandom);
            s_data   = DW'($urandom);
            consumed = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++; $display("FAIL random_cycle %0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        en = 1'b1; s_valid = 1'b0; consumed = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s_valid = 1'b0; consumed = 1'b0; s_data = '0;
        #1;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_enable_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Input-side elastic buffer that sits directly upstream of the transposed pipelined FIR filter. It accepts samples from a valid/ready source into a small FIFO. It presents them one at a time on the filter's `din`/`din_valid` port, holding each sample stable until the filter's one-cycle "consumed" pulse. It absorbs input bursts while the filter spends roughly FIR_DEPTH+4 cycles per output, and it flags samples the source pushes while the buffer is full.

## Interface
- DATA_WIDTH, 24, sample width in bits (matches the filter's DATA_WIDTH)
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  global enable; when low the block freezes all state and drives o_s_ready low
- iv_s_data  in  DATA_WIDTH  input sample (signed, passed through unmodified)
- i_s_valid  in  1  input sample valid
- o_s_ready  out  1  input ready; a beat transfers on a rising edge with i_s_valid && o_s_ready
- ov_dout  out  DATA_WIDTH  sample presented to the filter (filter iv_din)
- o_dout_valid  out  1  sample valid to the filter (filter i_din_valid)
- i_consumed  in  1  one-cycle pulse from the filter (filter o_ready); marks the presented sample as taken
- ov_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the output holding register
- o_overrun  out  1  sticky flag: i_s_valid seen while FIFO full

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH register/distributed array.
  - Write and read pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
  - A separate count register (0..FIFO_DEPTH) drives ov_level.
- o_s_ready = i_en && (count != FIFO_DEPTH), decoded combinationally from the count register.
- Push: on the edge where i_s_valid && o_s_ready, write iv_s_data at wr_ptr, then increment wr_ptr.
- Output FSM (state register, reset to IDLE). All transitions occur only when i_en = 1.
  - IDLE: if count > 0, load ov_dout ← mem[rd_ptr], increment rd_ptr (pop), go to PRESENT.
  - PRESENT: o_dout_valid = 1 and ov_dout is held constant. On i_consumed = 1, go to GAP.
  - GAP: o_dout_valid = 0 for exactly one cycle, then go to IDLE.
    - GAP guarantees the filter sees din_valid low after its S1 state, so each sample is accepted once.
- o_dout_valid is registered and high only in PRESENT.
- ov_dout keeps its last value outside PRESENT.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full boundary: the push is refused when count = FIFO_DEPTH, even if a pop occurs on the same edge, because ready is decoded from the registered count.
- Empty boundary: IDLE holds while count = 0. No pop is issued, and pointers are unchanged.
- i_consumed outside PRESENT is ignored.
- o_overrun is set on any edge with i_en && i_s_valid && (count == FIFO_DEPTH). It is cleared only by i_rst.
- i_en = 0:
  - No push, no pop, no state change.
  - o_dout_valid and ov_dout hold their values.
  - o_overrun is not set.

## Timing
- Reset (synchronous, i_rst high at an edge):
  - Output values: o_dout_valid = 0, ov_dout = 0, ov_level = 0, o_overrun = 0, o_s_ready = 1 when i_en = 1.
  - Internal state: FSM = IDLE; pointers and count = 0.
  - Array contents are not reset.
- Reset mid-operation discards all buffered samples and any presented sample. o_dout_valid is low in the cycle after the reset edge.
- Latency into an empty block:
  - Beat accepted at edge E.
  - ov_level = 1 after E.
  - Pop and load at E+1, giving ov_level = 0 and o_dout_valid = 1 after E+1.
- Release: i_consumed high at edge C gives o_dout_valid = 0 after C (GAP), then IDLE after C+1.
  - If the FIFO is non-empty, the next sample is loaded at C+2 and is valid after C+2.
  - Minimum spacing between presented samples is therefore 3 cycles.
- Sustained throughput is bounded by the filter; input accepts 1 beat/cycle until full.

## Test plan
- Single sample: after reset, push 0x123456 -> o_dout_valid rises 2 edges after acceptance with ov_dout = 0x123456. It stays high until the i_consumed pulse, then falls for ≥1 cycle.
- Burst to full (FIFO_DEPTH = 8):
  - Hold i_consumed low and push 10 samples 1..10 back-to-back.
  - Required: sample 1 is presented, samples 2..9 are accepted with ov_level = 8, and o_s_ready = 0.
  - Sample 10 stalls and o_overrun = 1.
  - Pulse i_consumed 9 times -> outputs 1..9 in order; sample 10 is then accepted and output.
- Wrap-around: stream 40 samples (0x000001..0x000028), with i_consumed pulsed 1 cycle after each o_dout_valid rise -> output sequence is identical and gapless in order, and ov_level never exceeds 8.
- Simultaneous push/pop:
  - With count = 3 and FSM in IDLE, push on the same edge as the pop -> count stays 3 and order is preserved.
  - With count = 8, push plus pop on the same edge -> push is refused and count = 7.
- Enable freeze: drop i_en for 5 cycles mid-PRESENT with i_s_valid and i_consumed pulsing -> no state, level, or output change, and o_overrun is unchanged.
- Reset mid-burst: i_rst with 5 samples buffered and one presented -> after the edge, o_dout_valid = 0, ov_level = 0, and o_overrun = 0. A subsequent new sample emerges first.
